// File: rtl/sr_latch_driver_if.sv
// Request/acknowledge interface between clocked control logic and the
// SR latch write-and-verify controller.
interface sr_latch_driver_if;
    logic req;   // write request, sampled only while the controller is idle
    logic val;   // target latch value (1 = set, 0 = clear)
    logic busy;  // controller is not idle
    logic ack;   // one-cycle completion pulse
    logic err;   // verification failure, valid with ack

    modport master (output req, val, input busy, ack, err);
    modport slave  (input req, val, output busy, ack, err);
endinterface

// File: rtl/sr_latch_driver.sv
// Write-and-verify controller for an external SR latch with enable.
// Drives s/r/en with one cycle of setup and hold around an en pulse,
// reads q/nq back through 2-flop synchronizers and retries on mismatch.
module sr_latch_driver #(
    parameter int PULSE_W   = 2,  // en high time per attempt, 1..15
    parameter int MAX_TRIES = 3   // attempts before reporting an error, 1..7
) (
    input  logic              clk,
    input  logic              rst_n,
    sr_latch_driver_if.slave  bus,
    output logic              s,
    output logic              r,
    output logic              en,
    input  logic              q,
    input  logic              nq
);

    localparam int TRIES_W = $clog2(MAX_TRIES + 1);

    typedef enum logic [2:0] {
        IDLE, SETUP, PULSE, HOLD, SETTLE, CHECK, DONE
    } state_t;

    state_t               state, state_next;
    logic                 tgt, tgt_next;
    logic [TRIES_W-1:0]   tries, tries_next;
    logic [3:0]           cnt, cnt_next;
    logic                 err_flag, err_flag_next;

    logic                 q_meta, q_sync, nq_meta, nq_sync;
    logic                 pass;

    logic                 busy_q, ack_q, err_q;
    logic                 s_d, r_d, en_d, busy_d, ack_d, err_d;

    assign bus.busy = busy_q;
    assign bus.ack  = ack_q;
    assign bus.err  = err_q;

    // The latch must hold the captured value on q and its complement on nq;
    // qs == nqs (invalid or forbidden state) therefore never passes.
    assign pass = (q_sync == tgt) && (nq_sync == ~tgt);

    // Bring the asynchronous latch outputs into the clock domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_meta  <= 1'b0;
            q_sync  <= 1'b0;
            nq_meta <= 1'b0;
            nq_sync <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the old value of its neighbour, which is what makes this a two-stage chain.
            q_meta  <= q;
            q_sync  <= q_meta;
            nq_meta <= nq;
            nq_sync <= nq_meta;
        end
    end

    // State register plus registered outputs; reset drops en immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            tgt      <= 1'b0;
            tries    <= '0;
            cnt      <= '0;
            err_flag <= 1'b0;
            s        <= 1'b0;
            r        <= 1'b0;
            en       <= 1'b0;
            busy_q   <= 1'b0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_next;
            tgt      <= tgt_next;
            tries    <= tries_next;
            cnt      <= cnt_next;
            err_flag <= err_flag_next;
            s        <= s_d;
            r        <= r_d;
            en       <= en_d;
            busy_q   <= busy_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
        end
    end

    // Next-state logic: sequencing, attempt counting and pass/fail decision.
    always_comb begin
        // NOTE: every variable gets a default before the case so that no path leaves it unassigned, which would infer a latch.
        state_next    = state;
        tgt_next      = tgt;
        tries_next    = tries;
        cnt_next      = cnt;
        err_flag_next = err_flag;
        unique case (state)
            IDLE: begin
                if (bus.req) begin
                    tgt_next   = bus.val;
                    tries_next = TRIES_W'(1);
                    state_next = SETUP;
                end
            end
            SETUP: begin
                cnt_next   = '0;
                state_next = PULSE;
            end
            PULSE: begin
                if (cnt == 4'(PULSE_W - 1)) begin
                    state_next = HOLD;
                end else begin
                    cnt_next = cnt + 4'd1;
                end
            end
            HOLD: begin
                cnt_next   = '0;
                state_next = SETTLE;
            end
            SETTLE: begin
                if (cnt == 4'd1) begin
                    state_next = CHECK;
                end else begin
                    cnt_next = cnt + 4'd1;
                end
            end
            CHECK: begin
                if (pass) begin
                    err_flag_next = 1'b0;
                    state_next    = DONE;
                end else if (tries < TRIES_W'(MAX_TRIES)) begin
                    // CHECK already presents s/r, so it serves as the setup
                    // cycle of the retry and the next pulse follows directly.
                    tries_next = tries + TRIES_W'(1);
                    cnt_next   = '0;
                    state_next = PULSE;
                end else begin
                    err_flag_next = 1'b1;
                    state_next    = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output decode from the next state, so the registered outputs line up
    // with the state they belong to and never depend combinationally on inputs.
    always_comb begin
        s_d    = 1'b0;
        r_d    = 1'b0;
        en_d   = 1'b0;
        busy_d = 1'b1;
        ack_d  = 1'b0;
        err_d  = 1'b0;
        unique case (state_next)
            IDLE: begin
                busy_d = 1'b0;
            end
            SETUP, HOLD, CHECK: begin
                s_d = tgt_next;
                r_d = ~tgt_next;
            end
            PULSE: begin
                s_d  = tgt_next;
                r_d  = ~tgt_next;
                en_d = 1'b1;
            end
            SETTLE: begin
                s_d = 1'b0;
            end
            DONE: begin
                ack_d = 1'b1;
                err_d = err_flag_next;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_sr_latch_driver.sv
// Directed and random bench for sr_latch_driver with a behavioural SR latch
// and a protocol monitor on the latch drive pins.
module tb_sr_latch_driver;

    localparam int PULSE_W   = 2;
    localparam int MAX_TRIES = 3;

    logic clk;
    logic rst_n;
    logic s, r, en;
    logic q_l, nq_l;
    logic stuck;

    sr_latch_driver_if bus ();

    sr_latch_driver #(.PULSE_W(PULSE_W), .MAX_TRIES(MAX_TRIES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .s     (s),
        .r     (r),
        .en    (en),
        .q     (q_l),
        .nq    (nq_l)
    );

    int n_cmp = 0;
    int n_err = 0;
    int viol  = 0;

    logic [31:0] s_vec, r_vec, en_vec, ack_vec, err_vec, busy_vec;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SR latch with enable; "stuck" pins it cleared.
    initial begin
        q_l  = 1'b0;
        nq_l = 1'b1;
    end
    always @(s or r or en or stuck) begin
        if (stuck) begin
            q_l  = 1'b0;
            nq_l = 1'b1;
        end else if (en && s && !r) begin
            q_l  = 1'b1;
            nq_l = 1'b0;
        end else if (en && r && !s) begin
            q_l  = 1'b0;
            nq_l = 1'b1;
        end
    end

    // Protocol monitor, sampled on the falling edge.
    logic en_prev, s_prev, r_prev;
    int   run;
    always @(negedge clk) begin
        int v;
        v = 0;
        if (!rst_n) begin
            en_prev <= 1'b0;
            s_prev  <= 1'b0;
            r_prev  <= 1'b0;
            run     <= 0;
        end else begin
            if (s && r) v++;
            if ((en || en_prev) && (s != s_prev || r != r_prev)) v++;
            if (en && !en_prev && !(s ^ r)) v++;
            if (!en && en_prev && run != PULSE_W) v++;
            if (v != 0) $display("invariant violation at %0t: s=%b r=%b en=%b", $time, s, r, en);
            viol    <= viol + v;
            run     <= en ? run + 1 : 0;
            en_prev <= en;
            s_prev  <= s;
            r_prev  <= r;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Issue a request; returns #1 after the sampling edge, i.e. in cycle 1.
    task automatic start_req(input logic v);
        bus.req = 1'b1;
        bus.val = v;
        @(posedge clk); #1;
        bus.req = 1'b0;
    endtask

    // Record outputs for cycles 1..n; req_mask drives req (with pval) per cycle.
    task automatic trace(input int n, input logic [31:0] req_mask, input logic pval);
        s_vec = '0; r_vec = '0; en_vec = '0; ack_vec = '0; err_vec = '0; busy_vec = '0;
        for (int c = 1; c <= n; c++) begin
            s_vec[c]    = s;
            r_vec[c]    = r;
            en_vec[c]   = en;
            ack_vec[c]  = bus.ack;
            err_vec[c]  = bus.err;
            busy_vec[c] = bus.busy;
            bus.req = req_mask[c];
            if (req_mask[c]) bus.val = pval;
            @(posedge clk); #1;
        end
        bus.req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  gap;
        logic v, got;
        rst_n   = 1'b0;
        bus.req = 1'b0;
        bus.val = 1'b0;
        stuck   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {bus.busy, bus.ack, bus.err, s, r, en}, 6'b0);
        #3 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_busy", bus.busy, 1'b0);

        // Set from q=0
        start_req(1'b1);
        trace(10, 32'h0, 1'b0);
        check("set_s",    s_vec & 32'h77E, 32'h1E);
        check("set_r",    r_vec, 32'h0);
        check("set_en",   en_vec, 32'hC);
        check("set_ack",  ack_vec, 32'h100);
        check("set_err",  err_vec, 32'h0);
        check("set_busy", busy_vec, 32'h1FE);
        check("set_q",    {q_l, nq_l}, 2'b10);

        // Clear after set
        start_req(1'b0);
        trace(10, 32'h0, 1'b0);
        check("clr_r",   r_vec & 32'h77E, 32'h1E);
        check("clr_s",   s_vec, 32'h0);
        check("clr_en",  en_vec, 32'hC);
        check("clr_ack", ack_vec, 32'h100);
        check("clr_err", err_vec, 32'h0);
        check("clr_q",   {q_l, nq_l}, 2'b01);

        // Stuck latch: three attempts then error
        stuck = 1'b1;
        start_req(1'b1);
        trace(22, 32'h0, 1'b0);
        stuck = 1'b0;
        check("stuck_en",   en_vec, 32'h0000_C30C);
        check("stuck_ack",  ack_vec, 32'h0010_0000);
        check("stuck_err",  err_vec, 32'h0010_0000);
        check("stuck_busy", busy_vec, 32'h001F_FFFE);

        // Busy rejection: clear requests in cycles 3 and 5 are ignored
        start_req(1'b1);
        trace(12, 32'h28, 1'b0);
        check("rej_s",   s_vec & 32'h77E, 32'h1E);
        check("rej_r",   r_vec, 32'h0);
        check("rej_ack", ack_vec, 32'h100);
        check("rej_q",   {q_l, nq_l}, 2'b10);

        // req held across DONE starts the next write in the first idle cycle
        start_req(1'b1);
        trace(18, 32'h3FE, 1'b1);
        check("b2b_ack", ack_vec, 32'h0002_0100);
        check("b2b_err", err_vec, 32'h0);

        // Asynchronous reset in the middle of PULSE
        start_req(1'b1);
        @(posedge clk); #1;
        check("arst_pre_en", en, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_en",   en, 1'b0);
        check("arst_s",    s, 1'b0);
        check("arst_busy", bus.busy, 1'b0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        start_req(1'b0);
        trace(10, 32'h0, 1'b0);
        check("arst_ack", ack_vec, 32'h100);
        check("arst_err", err_vec, 32'h0);
        check("arst_q",   {q_l, nq_l}, 2'b01);

        // Random transactions with req noise while busy
        for (int t = 0; t < 200; t++) begin
            v   = 1'($urandom_range(0, 1));
            gap = $urandom_range(1, 3);
            repeat (gap) begin
                @(posedge clk); #1;
            end
            start_req(v);
            got = 1'b0;
            for (int c = 0; c < 40 && !got; c++) begin
                if (bus.ack) begin
                    got = 1'b1;
                end else begin
                    bus.req = 1'($urandom_range(0, 1));
                    bus.val = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
            end
            bus.req = 1'b0;
            check("rand_ack", got, 1'b1);
            if (got) begin
                check("rand_err", bus.err, 1'b0);
                check("rand_q", {q_l, nq_l}, {v, ~v});
            end
        end

        repeat (3) @(posedge clk);
        #1;
        check("monitor_violations", viol, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
